// File: rtl/bpu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bpu_pkg
// Description : Shared types and helpers for the gshare branch predictor.
//               - state_t      : predictor FSM states (table init sweep / run)
//               - ENTRIES      : table depth for the default INDEX_W of 8
//               - ctr_init     : weakly-not-taken reset value of a counter
//               - ctr_sat_next : saturating +1 / -1 counter step
//               The helpers work on CTR_W_MAX-bit values. Callers truncate the
//               result to their own counter width, which must be <= CTR_W_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_INDEX_W = 8;
    localparam int ENTRIES         = 2 ** DEFAULT_INDEX_W;
    localparam int CTR_W_MAX       = 16;

    // 2**(ctr_w-1)-1 : highest value that still predicts not-taken
    function automatic logic [CTR_W_MAX-1:0] ctr_init(input int ctr_w);
        return CTR_W_MAX'((1 << (ctr_w - 1)) - 1);
    endfunction

    // Step a ctr_w-bit counter towards the resolved direction, holding at the
    // all-ones / all-zeros limits instead of wrapping.
    function automatic logic [CTR_W_MAX-1:0] ctr_sat_next(
        input logic [CTR_W_MAX-1:0] ctr,
        input logic                 taken,
        input int                   ctr_w
    );
        logic [CTR_W_MAX-1:0] max_v;
        max_v = CTR_W_MAX'((1 << ctr_w) - 1);
        if (taken) begin
            return (ctr == max_v) ? ctr : ctr + CTR_W_MAX'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTR_W_MAX'(1);
    endfunction

endpackage : bpu_pkg
`default_nettype wire

// File: rtl/gshare_ctr_table.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gshare_ctr_table
// Description : Array of CTR_W-bit saturating counters for the gshare
//               predictor. One asynchronous read port for prediction and one
//               synchronous write port shared by the init sweep and the
//               execute-stage update. No per-entry reset: the owner clears the
//               array with an init sweep.
// Ports       : clk      - clock, rising edge
//               rd_addr  - prediction read index
//               rd_data  - counter at rd_addr (combinational)
//               wr_en    - write strobe
//               wr_addr  - write index
//               wr_init  - 1: load the init value, 0: saturating count step
//               wr_taken - count direction when wr_init=0
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_ctr_table
    import bpu_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic [INDEX_W-1:0] rd_addr,
    output logic [CTR_W-1:0]   rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_addr,
    input  logic               wr_init,
    input  logic               wr_taken
);

    localparam int DEPTH = 2 ** INDEX_W;

    logic [CTR_W-1:0] r_mem [DEPTH];
    logic [CTR_W-1:0] w_cur;
    logic [CTR_W-1:0] w_wdata;

    // The update is a read-modify-write on the write address; the step is
    // folded into the write port so the prediction read port stays free.
    assign w_cur   = r_mem[wr_addr];
    assign w_wdata = wr_init ? CTR_W'(ctr_init(CTR_W))
                             : CTR_W'(ctr_sat_next(CTR_W_MAX'(w_cur), wr_taken, CTR_W));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= w_wdata;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : gshare_ctr_table
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gshare_predictor
// Description : Gshare branch direction predictor. The index is the PC bits
//               XOR the global history register (GHR). The GHR is shifted
//               speculatively at prediction time and repaired from the
//               execute-stage checkpoint on a mispredict. After reset an init
//               sweep writes every counter to weakly-not-taken before ready
//               is raised.
//               Optional macro BHT_FWD_EN: forward a same-cycle update to the
//               prediction read when both use the same index.
// Ports       : clk, reset (async, active-high)
//               ready          - table valid (low during the init sweep)
//               pred_pc/pred_valid          - fetch-side request
//               predict_taken/pred_index/pred_ghr - prediction and checkpoint
//               upd_en/upd_index/upd_ghr/upd_taken/upd_mispredict - resolve
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import bpu_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 8,
    parameter int PC_LSB  = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               ready,
    input  logic [31:0]        pred_pc,
    input  logic               pred_valid,
    output logic               predict_taken,
    output logic [INDEX_W-1:0] pred_index,
    output logic [GHR_W-1:0]   pred_ghr,
    input  logic               upd_en,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [GHR_W-1:0]   upd_ghr,
    input  logic               upd_taken,
    input  logic               upd_mispredict
);

    localparam logic [INDEX_W-1:0] PTR_LAST = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_ptr;
    logic [GHR_W-1:0]   r_ghr;
    logic [GHR_W-1:0]   w_ghr_nxt;
    logic [INDEX_W-1:0] w_idx;
    logic [CTR_W-1:0]   w_rd_data;
    logic [CTR_W-1:0]   w_ctr_eff;
    logic               w_in_init;
    logic               w_wr_en;
    logic [INDEX_W-1:0] w_wr_addr;
    logic               w_unused;

    assign w_in_init = (r_state == INIT);

    // ------------------------------------------------------------------
    // State, sweep pointer and GHR
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_ghr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ghr   <= w_ghr_nxt;
            if (w_in_init) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ghr_nxt   = r_ghr;
        case (r_state)
            INIT: begin
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Repair beats the speculative shift: the front end is being
                // flushed, so that prediction never happened.
                if (upd_en && upd_mispredict) begin
                    w_ghr_nxt = GHR_W'({upd_ghr, upd_taken});
                end else if (pred_valid) begin
                    w_ghr_nxt = GHR_W'({r_ghr, predict_taken});
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Index hash and table access
    // ------------------------------------------------------------------
    assign w_idx = pred_pc[PC_LSB+INDEX_W-1:PC_LSB] ^ INDEX_W'(r_ghr);

    // Single write port: the sweep owns it during INIT, updates during RUN.
    assign w_wr_en   = w_in_init | upd_en;
    assign w_wr_addr = w_in_init ? r_ptr : upd_index;

    gshare_ctr_table #(
        .INDEX_W (INDEX_W),
        .CTR_W   (CTR_W)
    ) u_table (
        .clk      (clk),
        .rd_addr  (w_idx),
        .rd_data  (w_rd_data),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr),
        .wr_init  (w_in_init),
        .wr_taken (upd_taken)
    );

`ifdef BHT_FWD_EN
    // Write-to-read bypass: the read already targets upd_index, so the
    // forwarded value is simply the stepped read data.
    assign w_ctr_eff = (upd_en && (upd_index == w_idx))
                     ? CTR_W'(ctr_sat_next(CTR_W_MAX'(w_rd_data), upd_taken, CTR_W))
                     : w_rd_data;
`else
    assign w_ctr_eff = w_rd_data;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready         = (r_state == RUN);
    assign predict_taken = ready & w_ctr_eff[CTR_W-1];
    assign pred_index    = w_idx;
    assign pred_ghr      = r_ghr;

    // PC bits outside the index window, the top checkpoint bit and the low
    // counter bits do not influence any output.
    assign w_unused = ^{pred_pc, upd_ghr, w_ctr_eff};

endmodule : gshare_predictor
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gshare_predictor
// Description : Self-checking bench for gshare_predictor (default parameters:
//               INDEX_W=8, CTR_W=2, GHR_W=8, PC_LSB=2). A behavioural model
//               (counter array + history integer) predicts every output.
//               Honours BHT_FWD_EN when the bench is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        predict_taken;
    logic [7:0]  pred_index;
    logic [7:0]  pred_ghr;
    logic        upd_en;
    logic [7:0]  upd_index;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

`ifdef BHT_FWD_EN
    localparam bit EXP_FWD = 1'b1;
`else
    localparam bit EXP_FWD = 1'b0;
`endif

    gshare_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .ready          (ready),
        .pred_pc        (pred_pc),
        .pred_valid     (pred_valid),
        .predict_taken  (predict_taken),
        .pred_index     (pred_index),
        .pred_ghr       (pred_ghr),
        .upd_en         (upd_en),
        .upd_index      (upd_index),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    int m_tbl [256];
    int m_ghr;
    bit m_ready;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return ((pc >> 2) & 255) ^ m_ghr;
    endfunction

    function automatic bit m_pred(input logic [31:0] pc, input bit ue, input int ui, input bit ut);
        int i;
        int c;
        if (!m_ready) return 1'b0;
        i = m_idx(pc);
        c = m_tbl[i];
        if (EXP_FWD && ue && (ui == i)) c = sat(c, ut);
        return c >= 2;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_tbl[i] = 1;
        m_ghr = 0;
    endtask

    task automatic idle_inputs();
        pred_valid     = 1'b0;
        upd_en         = 1'b0;
        upd_index      = '0;
        upd_ghr        = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    // Called at a negedge; drives one cycle, checks all outputs against the
    // model, advances the model at the posedge and returns at the next negedge.
    task automatic step(input logic [31:0] pc, input bit pv, input bit ue, input int ui,
                        input int ug, input bit ut, input bit um, output bit obs);
        bit p;
        pred_pc        = pc;
        pred_valid     = pv;
        upd_en         = ue;
        upd_index      = ui[7:0];
        upd_ghr        = ug[7:0];
        upd_taken      = ut;
        upd_mispredict = um;
        #1;
        p   = m_pred(pc, ue, ui, ut);
        obs = predict_taken;
        check_val("predict_taken", predict_taken, p);
        check_val("pred_index", pred_index, m_idx(pc));
        check_val("pred_ghr", pred_ghr, m_ghr);
        check_val("ready", ready, m_ready);
        @(posedge clk);
        if (m_ready) begin
            if (ue) m_tbl[ui] = sat(m_tbl[ui], ut);
            if (ue && um)  m_ghr = ((ug << 1) | ut) & 255;
            else if (pv)   m_ghr = ((m_ghr << 1) | p) & 255;
        end
        @(negedge clk);
    endtask

    // Called right after reset is released at a negedge. Hammers the request
    // and update ports (which must be ignored) while counting cycles to ready.
    task automatic sweep_and_check(input string tag);
        int cyc;
        int sweep_pred;
        cyc        = 0;
        sweep_pred = 0;
        while (cyc < 400) begin
            pred_pc        = $urandom;
            pred_valid     = 1'b1;
            upd_en         = 1'b1;
            upd_index      = 8'($urandom);
            upd_ghr        = 8'($urandom);
            upd_taken      = 1'b1;
            upd_mispredict = 1'b1;
            @(posedge clk);
            cyc++;
            #1;
            if (ready) break;
            if (predict_taken) sweep_pred++;
        end
        idle_inputs();
        check_val({tag, "_ready_cycles"}, cyc, 256);
        check_val({tag, "_pred_in_sweep"}, sweep_pred, 0);
        check_val({tag, "_ghr_after_sweep"}, pred_ghr, 0);
        model_clear();
        m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic random_phase(input int n);
        logic [31:0] pc;
        int          ui;
        bit          obs;
        for (int k = 0; k < n; k++) begin
            pc = $urandom;
            ui = ($urandom_range(0, 3) == 0) ? m_idx(pc) : int'($urandom_range(0, 255));
            step(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ui,
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), obs);
        end
    endtask

    initial begin
        bit obs;
        reset   = 1'b1;
        pred_pc = 32'h0000_0AB4;
        idle_inputs();
        m_ready = 1'b0;
        model_clear();

        // ---- reset state and init sweep ----
        @(negedge clk);
        #1;
        check_val("rst_ready", ready, 0);
        check_val("rst_predict", predict_taken, 0);
        check_val("rst_ghr", pred_ghr, 0);
        check_val("rst_index", pred_index, 8'hAD);
        @(negedge clk);
        reset = 1'b0;
        sweep_and_check("sweep1");

        // ---- counter saturation on index 5 (pc 0x14, GHR 0) ----
        step(32'h1000, 0, 1, 5, 0, 1, 0, obs);
        step(32'h1000, 0, 1, 5, 0, 1, 0, obs);
        step(32'h14, 0, 0, 0, 0, 0, 0, obs); check_val("sat_11_taken", obs, 1);
        step(32'h1000, 0, 1, 5, 0, 1, 0, obs);
        step(32'h1000, 0, 1, 5, 0, 0, 0, obs);
        step(32'h14, 0, 0, 0, 0, 0, 0, obs); check_val("sat_hold_hi", obs, 1);
        step(32'h1000, 0, 1, 5, 0, 0, 0, obs);
        step(32'h14, 0, 0, 0, 0, 0, 0, obs); check_val("sat_01", obs, 0);
        step(32'h1000, 0, 1, 5, 0, 0, 0, obs);
        step(32'h1000, 0, 1, 5, 0, 0, 0, obs);
        step(32'h1000, 0, 1, 5, 0, 1, 0, obs);
        step(32'h1000, 0, 1, 5, 0, 1, 0, obs);
        step(32'h14, 0, 0, 0, 0, 0, 0, obs); check_val("sat_hold_lo", obs, 1);

        // ---- speculative GHR shift: train 4,5,6 taken, predict at pc 0x14 ----
        for (int e = 4; e <= 6; e++) begin
            step(32'h1000, 0, 1, e, 0, 1, 0, obs);
            step(32'h1000, 0, 1, e, 0, 1, 0, obs);
        end
        check_val("ghr_start", pred_ghr, 8'h00);
        step(32'h14, 1, 0, 0, 0, 0, 0, obs); check_val("spec1_pred", obs, 1);
        check_val("ghr_01", pred_ghr, 8'h01);
        step(32'h14, 1, 0, 0, 0, 0, 0, obs); check_val("spec2_pred", obs, 1);
        check_val("ghr_03", pred_ghr, 8'h03);
        step(32'h14, 1, 0, 0, 0, 0, 0, obs); check_val("spec3_pred", obs, 1);
        check_val("ghr_07", pred_ghr, 8'h07);

        // ---- repair beats speculative shift ----
        step(32'h14, 1, 1, 9, 8'h0A, 1, 1, obs);
        check_val("repair_ghr", pred_ghr, 8'h15);
        // correct-prediction update leaves the GHR alone
        step(32'h40, 0, 1, 9, 8'h33, 1, 0, obs);
        check_val("no_repair_ghr", pred_ghr, 8'h15);

        random_phase(300);

        // ---- reset from RUN, then again at sweep pointer 100 ----
        step(32'h1000, 0, 1, 200, 0, 1, 0, obs);
        step(32'h1000, 0, 1, 200, 0, 1, 0, obs);
        reset = 1'b1;
        #1;
        check_val("rst_run_ready", ready, 0);
        check_val("rst_run_ghr", pred_ghr, 0);
        m_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_mid_ready", ready, 0);
        @(negedge clk);
        reset = 1'b0;
        sweep_and_check("sweep2");
        step(32'h320, 0, 0, 0, 0, 0, 0, obs); check_val("reinit_200", obs, 0);
        step(32'h14, 0, 0, 0, 0, 0, 0, obs);  check_val("reinit_5", obs, 0);

        // ---- same-cycle update + predict, same index, counter 01, taken ----
        step(32'h14, 0, 1, 5, 0, 1, 0, obs);
        check_val("fwd_bypass", obs, EXP_FWD);

        random_phase(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_gshare_predictor
`default_nettype wire
